// File: rtl/cache_line_bus_arbiter_pkg.sv
// Shared types and widths for the cache-line bus arbiter.
// Optional build macro: ARB_ROUND_ROBIN_EN (see cache_arb_pick).
package cache_line_bus_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 128;

  typedef enum logic [2:0] {
    IDLE,
    I_RD_REQ,
    I_RD_WAIT,
    D_RD_REQ,
    D_RD_WAIT,
    D_WR_REQ,
    D_WR_WAIT
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_I,
    GNT_D_RD,
    GNT_D_WR
  } grant_e;

  // Round-robin pointer: RR_I after reset, meaning the DCache class has the next turn.
  typedef enum logic {
    RR_I,
    RR_D
  } rr_e;

endpackage

// File: rtl/cache_arb_pick.sv
// Combinational winner select between ICache and DCache requesters.
// ARB_ROUND_ROBIN_EN defined: the ICache and DCache classes alternate when both
// are pending (1-bit pointer flips on every grant); otherwise DCache always wins.
// Within the DCache class a write-back always beats a read.
module cache_arb_pick
  import cache_line_bus_arbiter_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
  input  logic   clk,
  input  logic   rst,
  input  logic   grant_en,
`endif
  input  logic   i_req,
  input  logic   d_rd_req,
  input  logic   d_wr_req,
  output logic   valid,
  output grant_e gnt
);

  logic   d_any;
  grant_e d_gnt;

  // DCache class request and its internal winner
  always_comb begin
    d_any = d_rd_req | d_wr_req;
    d_gnt = d_wr_req ? GNT_D_WR : GNT_D_RD;
  end

`ifdef ARB_ROUND_ROBIN_EN
  rr_e rr_q, rr_d;

  // Pointer flips on each accepted grant
  always_comb begin
    rr_d = rr_q;
    if (grant_en) begin
      rr_d = (rr_q == RR_I) ? RR_D : RR_I;
    end
  end

  // Pointer register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q <= RR_I;
    end else begin
      rr_q <= rr_d;
    end
  end

  // Class alternation: DCache wins when it holds the turn or ICache is idle
  always_comb begin
    valid = d_any | i_req;
    gnt   = GNT_I;
    if (d_any && ((rr_q == RR_I) || !i_req)) begin
      gnt = d_gnt;
    end
  end
`else
  // Fixed priority: d_wr > d_rd > i_rd
  always_comb begin
    valid = d_any | i_req;
    gnt   = d_any ? d_gnt : GNT_I;
  end
`endif

endmodule

// File: rtl/cache_line_bus_arbiter.sv
// Shares one cache-line bridge between ICache (read) and DCache (read/write-back).
// One transaction outstanding at a time; winner captured in IDLE, request driven
// from registers in *_REQ, completion forwarded combinationally in *_WAIT.
// Optional build macro: ARB_ROUND_ROBIN_EN (class alternation instead of fixed priority).
module cache_line_bus_arbiter
  import cache_line_bus_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              i_rd_rdy,
  output logic              i_ret_valid,
  output logic [LINE_W-1:0] i_ret_data,
  input  logic              d_rd_req,
  input  logic [ADDR_W-1:0] d_rd_addr,
  output logic              d_rd_rdy,
  output logic              d_ret_valid,
  output logic [LINE_W-1:0] d_ret_data,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [LINE_W-1:0] d_wr_data,
  output logic              d_wr_rdy,
  output logic              d_wr_valid,
  output logic              m_rd_req,
  output logic [ADDR_W-1:0] m_rd_addr,
  output logic              m_wr_req,
  output logic [ADDR_W-1:0] m_wr_addr,
  output logic [LINE_W-1:0] m_wr_data,
  input  logic              m_rd_rdy,
  input  logic              m_ret_valid,
  input  logic [LINE_W-1:0] m_ret_data,
  input  logic              m_wr_rdy,
  input  logic              m_wr_valid
);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [LINE_W-1:0] wr_data_q, wr_data_d;
  logic              pick_valid;
  grant_e            pick_gnt;

`ifdef ARB_ROUND_ROBIN_EN
  logic grant_en;
  assign grant_en = (state_q == IDLE) && pick_valid;
`endif

  cache_arb_pick u_pick (
`ifdef ARB_ROUND_ROBIN_EN
    .clk      (clk),
    .rst      (rst),
    .grant_en (grant_en),
`endif
    .i_req    (i_rd_req),
    .d_rd_req (d_rd_req),
    .d_wr_req (d_wr_req),
    .valid    (pick_valid),
    .gnt      (pick_gnt)
  );

  assign m_rd_addr = rd_addr_q;
  assign m_wr_addr = wr_addr_q;
  assign m_wr_data = wr_data_q;

  // State and captured-request registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Next state, capture and handshake outputs
  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    m_rd_req    = 1'b0;
    m_wr_req    = 1'b0;
    i_rd_rdy    = 1'b0;
    i_ret_valid = 1'b0;
    i_ret_data  = '0;
    d_rd_rdy    = 1'b0;
    d_ret_valid = 1'b0;
    d_ret_data  = '0;
    d_wr_rdy    = 1'b0;
    d_wr_valid  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          unique case (pick_gnt)
            GNT_D_WR: begin
              wr_addr_d = d_wr_addr;
              wr_data_d = d_wr_data;
              state_d   = D_WR_REQ;
            end
            GNT_D_RD: begin
              rd_addr_d = d_rd_addr;
              state_d   = D_RD_REQ;
            end
            default: begin
              rd_addr_d = i_rd_addr;
              state_d   = I_RD_REQ;
            end
          endcase
        end
      end
      I_RD_REQ: begin
        m_rd_req = 1'b1;
        if (m_rd_rdy) begin
          i_rd_rdy = 1'b1;
          state_d  = I_RD_WAIT;
        end
      end
      I_RD_WAIT: begin
        if (m_ret_valid) begin
          i_ret_valid = 1'b1;
          i_ret_data  = m_ret_data;
          state_d     = IDLE;
        end
      end
      D_RD_REQ: begin
        m_rd_req = 1'b1;
        if (m_rd_rdy) begin
          d_rd_rdy = 1'b1;
          state_d  = D_RD_WAIT;
        end
      end
      D_RD_WAIT: begin
        if (m_ret_valid) begin
          d_ret_valid = 1'b1;
          d_ret_data  = m_ret_data;
          state_d     = IDLE;
        end
      end
      D_WR_REQ: begin
        m_wr_req = 1'b1;
        if (m_wr_rdy) begin
          d_wr_rdy = 1'b1;
          state_d  = D_WR_WAIT;
        end
      end
      D_WR_WAIT: begin
        if (m_wr_valid) begin
          d_wr_valid = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
